// File: rtl/cartridge_dump_master.sv
// Cartridge ROM dump initiator: walks bank 0 then banks 1..NUM_BANKS-1 (via 0x2000 select) and streams every byte.
// Latency: RD_CYCLES clocks of RE_L low per byte, plus WR_CYCLES + 1 gap clock per bank switch; all outputs registered.
// Backpressure: holds the byte in PUSH with strobes idle until I_BYTE_READY; optional DUMP_CHECKSUM_EN adds O_CHECKSUM.
module cartridge_dump_master #(
    parameter int NUM_BANKS = 128,
    parameter int RD_CYCLES = 4,
    parameter int WR_CYCLES = 2
) (
    input  logic        I_CLK,
    input  logic        I_RESET_L,
    input  logic        I_START,
    output logic        O_BUSY,
    output logic        O_DONE,
    output logic [15:0] O_CARTRIDGE_ADDR,
    output logic [7:0]  O_CARTRIDGE_DATA,
    output logic        O_DATA_OE,
    input  logic [7:0]  I_CARTRIDGE_DATA,
    output logic        O_CARTRIDGE_RE_L,
    output logic        O_CARTRIDGE_WE_L,
    output logic [7:0]  O_BYTE,
    output logic        O_BYTE_VALID,
    input  logic        I_BYTE_READY,
`ifdef DUMP_CHECKSUM_EN
    output logic [15:0] O_CHECKSUM,
`endif
    output logic [20:0] O_BYTE_INDEX
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SEL_WR = 3'd1;
    localparam logic [2:0] S_GAP    = 3'd2;
    localparam logic [2:0] S_RD     = 3'd3;
    localparam logic [2:0] S_PUSH   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam int CMAX = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] RD_LAST = CW'(RD_CYCLES - 1);
    localparam logic [CW-1:0] WR_LAST = CW'(WR_CYCLES - 1);
    localparam logic [6:0]    BANK_LAST = 7'(NUM_BANKS - 1);

    logic [2:0]    state_q, state_d;
    logic [6:0]    bank_q, bank_d;
    logic [13:0]   off_q, off_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   addr_q, addr_d;
    logic [7:0]    wdat_q, wdat_d;
    logic          oe_q, oe_d;
    logic          re_l_q, re_l_d;
    logic          we_l_q, we_l_d;
    logic [7:0]    byte_q, byte_d;
    logic          vld_q, vld_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [20:0]   idx_q, idx_d;
`ifdef DUMP_CHECKSUM_EN
    logic [15:0]   csum_q, csum_d;
`endif

    logic [13:0] off_inc;
    logic [6:0]  bank_inc;

    // Bank 0 lives in the fixed window, every other bank in the switchable one.
    function automatic logic [15:0] rd_addr(input logic [6:0] bank, input logic [13:0] off);
        return (bank == 7'd0) ? {2'b00, off} : {2'b01, off};
    endfunction

    always_comb begin
        state_d  = state_q;
        bank_d   = bank_q;
        off_d    = off_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdat_d   = wdat_q;
        oe_d     = oe_q;
        re_l_d   = re_l_q;
        we_l_d   = we_l_q;
        byte_d   = byte_q;
        vld_d    = vld_q;
        busy_d   = busy_q;
        done_d   = done_q;
        idx_d    = idx_q;
`ifdef DUMP_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        off_inc  = off_q + 14'd1;
        bank_inc = bank_q + 7'd1;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (I_START) begin
                    bank_d  = 7'd0;
                    off_d   = 14'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    addr_d  = 16'h0000;
                    re_l_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RD;
`ifdef DUMP_CHECKSUM_EN
                    csum_d  = 16'h0000;
`endif
                end
            end
            S_SEL_WR: begin
                if (cnt_q == WR_LAST) begin
                    we_l_d  = 1'b1;
                    oe_d    = 1'b0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                addr_d  = rd_addr(bank_q, off_q);
                re_l_d  = 1'b0;
                cnt_d   = '0;
                state_d = S_RD;
            end
            S_RD: begin
                if (cnt_q == RD_LAST) begin
                    byte_d  = I_CARTRIDGE_DATA;
                    idx_d   = {bank_q, off_q};
                    re_l_d  = 1'b1;
                    vld_d   = 1'b1;
                    state_d = S_PUSH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PUSH: begin
                if (I_BYTE_READY) begin
                    vld_d = 1'b0;
`ifdef DUMP_CHECKSUM_EN
                    csum_d = csum_q + {8'h00, byte_q};
`endif
                    if (off_q != 14'h3FFF) begin
                        off_d   = off_inc;
                        addr_d  = rd_addr(bank_q, off_inc);
                        re_l_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = S_RD;
                    end else if (bank_q < BANK_LAST) begin
                        off_d   = 14'd0;
                        bank_d  = bank_inc;
                        addr_d  = 16'h2000;
                        wdat_d  = {1'b0, bank_inc};
                        oe_d    = 1'b1;
                        we_l_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = S_SEL_WR;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                re_l_d  = 1'b1;
                we_l_d  = 1'b1;
                oe_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            state_q <= S_IDLE;
            bank_q  <= 7'd0;
            off_q   <= 14'd0;
            cnt_q   <= '0;
            addr_q  <= 16'h0000;
            wdat_q  <= 8'h00;
            oe_q    <= 1'b0;
            re_l_q  <= 1'b1;
            we_l_q  <= 1'b1;
            byte_q  <= 8'h00;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= 21'd0;
`ifdef DUMP_CHECKSUM_EN
            csum_q  <= 16'h0000;
`endif
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            oe_q    <= oe_d;
            re_l_q  <= re_l_d;
            we_l_q  <= we_l_d;
            byte_q  <= byte_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
`ifdef DUMP_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign O_BUSY           = busy_q;
    assign O_DONE           = done_q;
    assign O_CARTRIDGE_ADDR = addr_q;
    assign O_CARTRIDGE_DATA = wdat_q;
    assign O_DATA_OE        = oe_q;
    assign O_CARTRIDGE_RE_L = re_l_q;
    assign O_CARTRIDGE_WE_L = we_l_q;
    assign O_BYTE           = byte_q;
    assign O_BYTE_VALID     = vld_q;
    assign O_BYTE_INDEX     = idx_q;
`ifdef DUMP_CHECKSUM_EN
    assign O_CHECKSUM       = csum_q;
`endif

endmodule

// File: doc/cartridge_dump_master.md
Name: cartridge_dump_master

Overview:
- Bus initiator for the cartridge CPU-side interface: the master that drives address, RE_L and WE_L toward the cartridge/MBC responder.
- Given a start pulse, it walks the whole ROM image. Bank 0 is read at 0x0000-0x3FFF. For each bank 1..NUM_BANKS-1 it writes the bank number to 0x2000, then reads 0x4000-0x7FFF.
- Every byte read is presented on a valid/ready byte stream for the debug UART/flash-verify path.
- Sits beside the CPU and muxes onto the cartridge bus while the CPU is held.

Parameters:
- NUM_BANKS, 128, ROM banks to dump (2..128); bank index is 7 bits.
- RD_CYCLES, 4, clocks I_CARTRIDGE_RE_L is held low per read (>=1); data sampled on the last of these.
- WR_CYCLES, 2, clocks I_CARTRIDGE_WE_L is held low per bank-select write (>=1).

Ports:
- I_CLK  in  1  system clock
- I_RESET_L  in  1  asynchronous active-low reset
- I_START  in  1  one-cycle start pulse; ignored unless idle or done
- O_BUSY  out  1  high from the cycle after accepted start until DONE
- O_DONE  out  1  high after the last byte is accepted; cleared by the next start
- O_CARTRIDGE_ADDR  out  16  cartridge bus address
- O_CARTRIDGE_DATA  out  8  write data; the top level drives the inout bus when O_DATA_OE=1
- O_DATA_OE  out  1  high only while WE_L is low
- I_CARTRIDGE_DATA  in  8  read data from the cartridge bus
- O_CARTRIDGE_RE_L  out  1  read strobe, active low
- O_CARTRIDGE_WE_L  out  1  write strobe, active low
- O_BYTE  out  8  dumped byte
- O_BYTE_VALID  out  1  O_BYTE valid
- I_BYTE_READY  in  1  consumer accepts when VALID&READY at the clock edge
- O_BYTE_INDEX  out  21  linear image offset of O_BYTE: bank*16384 + addr[13:0]

Behaviour:
Reset (async, immediate, mid-operation included):
- State IDLE; RE_L=1, WE_L=1, OE=0.
- ADDR=0, DATA=0, BYTE=0, VALID=0, BUSY=0, DONE=0, INDEX=0.
- Internal bank=0, offset=0.

All outputs are registered.

States:
- IDLE: on I_START, set bank=0, offset=0, BUSY=1, DONE=0, go to RD.
- SEL_WR: ADDR=0x2000, DATA={1'b0,bank}, OE=1, WE_L=0 for WR_CYCLES clocks. Then WE_L=1, OE=0, go to GAP.
- GAP: one idle clock with both strobes high, then go to RD. GAP guarantees the responder sees the bank register update before the next read.
- RD: ADDR = (bank==0) ? {2'b00,offset} : {2'b01,offset}; RE_L=0 for RD_CYCLES clocks. On the last clock, capture I_CARTRIDGE_DATA into O_BYTE, set INDEX, RE_L=1, VALID=1, go to PUSH.
- PUSH: hold BYTE, INDEX and VALID stable until READY. On acceptance, VALID=0 and:
  - offset!=0x3FFF: offset+1, go to RD.
  - offset==0x3FFF and bank<NUM_BANKS-1: offset=0, bank+1, go to SEL_WR.
  - otherwise: go to DONE.
- DONE: BUSY=0, DONE=1. I_START restarts exactly as from IDLE.

Rules:
- The bus is idle (strobes high) whenever in PUSH. RE_L and WE_L are never low together.
- ADDR is stable for the whole strobe-low window and changes only while both strobes are high.
- I_START while BUSY has no effect.
- Bank 0 is never written; the first SEL_WR writes 0x01.
- Offset is 14 bits. INDEX is the 21-bit concatenation {bank, offset}.

Optional Feature:
- Macro DUMP_CHECKSUM_EN.
- With it defined:
  - Extra output port O_CHECKSUM (16 bits): running modulo-2^16 sum of every accepted byte.
  - Cleared on reset and on accepted start.
  - Updated on the accepted handshake cycle; final value valid when DONE=1.
- Without it: no port and no adder. The rest of the behaviour is identical.

Test Plan:
- Reset mid-read: assert I_RESET_L=0 while RE_L=0 and bank=2 -> same cycle RE_L=1, VALID=0, BUSY=0; after release, idle until the next start.
- NUM_BANKS=2, RD_CYCLES=2, WR_CYCLES=2, READY=1, cartridge model returns addr[7:0]^bank -> 32768 bytes; INDEX runs 0..32767 contiguously.
  - Exactly one write: addr 0x2000, data 0x01, WE_L low for 2 clocks, followed by the 1-clock GAP.
  - Bytes for INDEX 16384.. come from address 0x4000..; DONE=1 after the last byte.
- Backpressure: hold READY=0 for 10 cycles at INDEX 5 -> BYTE, VALID and INDEX stable; no strobe activity; resumes with INDEX 6 the clock after READY=1.
- Bank boundary with NUM_BANKS=4 -> writes 0x01, 0x02, 0x03 to 0x2000 in order, each right after the offset-0x3FFF byte of the previous bank; no write of 0x00.
- Start while busy: pulse I_START at INDEX 100 -> no restart, dump continues; start after DONE -> DONE=0, INDEX returns to 0.
- DUMP_CHECKSUM_EN: NUM_BANKS=2, all bytes 0xFF -> O_CHECKSUM = 32768*255 mod 65536 = 0x8000 at DONE.
